// File: rtl/data_bus_pkg.sv
// Shared constants for the data-side bus responder.
// MMIO map, KEY_STATUS layout and region decode type.
package data_bus_pkg;

  localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;
  localparam logic [31:0] KEY_STATUS_ADDR = MMIO_BASE + 32'h00;
  localparam logic [31:0] KEY_DATA_ADDR   = MMIO_BASE + 32'h04;
  localparam logic [31:0] KEY_POP_ADDR    = MMIO_BASE + 32'h08;
  localparam logic [31:0] DISP_ADDR       = MMIO_BASE + 32'h0C;
  localparam logic [31:0] CYCLES_ADDR     = MMIO_BASE + 32'h10;

  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_CNT_LSB  = 4;
  localparam int STAT_CNT_MSB  = 7;
  localparam int STAT_OVF      = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_KSTAT,
    REG_KDATA,
    REG_KPOP,
    REG_DISP,
    REG_CYCLES
  } region_e;

  function automatic logic [31:0] key_status(
    input logic       nonempty,
    input logic       full,
    input logic       ovf,
    input logic [3:0] cnt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_NONEMPTY] = nonempty;
    s[STAT_FULL] = full;
    s[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    s[STAT_OVF] = ovf;
    return s;
  endfunction

endpackage

// File: rtl/data_bus_responder_key_fifo.sv
// Keypad input queue: circular buffer with count and sticky overflow.
// A pop frees a slot for a same-cycle push, so full+push+pop never overflows.
module key_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  input  logic                        pop,
  input  logic                        clr_ovf,
  output logic [7:0]                  head,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow
);
  import data_bus_pkg::*;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && full && !pop;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // set wins over a same-cycle clear
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port memory end of the single-cycle core: word RAM plus
// calculator MMIO (keypad queue, display, cycle counter).
module data_bus_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic [31:0] disp
);
  import data_bus_pkg::*;

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cycles;
  logic [AW-1:0] ram_idx;
  region_e     region;

  logic          kf_pop;
  logic          kf_clr;
  logic [7:0]    kf_head;
  logic [CW-1:0] kf_count;
  logic          kf_full;
  logic          kf_empty;
  logic          kf_ovf;

  assign ram_idx = addr[AW+1:2];

  // bits [1:0] ignored: word access only
  always_comb begin
    region = REG_NONE;
    if (addr < RAM_BYTES)
      region = REG_RAM;
    else begin
      unique case ({addr[31:2], 2'b00})
        KEY_STATUS_ADDR: region = REG_KSTAT;
        KEY_DATA_ADDR:   region = REG_KDATA;
        KEY_POP_ADDR:    region = REG_KPOP;
        DISP_ADDR:       region = REG_DISP;
        CYCLES_ADDR:     region = REG_CYCLES;
        default:         region = REG_NONE;
      endcase
    end
  end

  assign kf_pop = memwrite && (region == REG_KPOP);
  assign kf_clr = kf_pop && writedata[1];

  key_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_key_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (key_valid),
    .push_data(key_code),
    .pop      (kf_pop),
    .clr_ovf  (kf_clr),
    .head     (kf_head),
    .count    (kf_count),
    .full     (kf_full),
    .empty    (kf_empty),
    .overflow (kf_ovf)
  );

  always_comb begin
    readdata = '0;
    unique case (region)
      REG_RAM:    readdata = ram[ram_idx];
      REG_KSTAT:  readdata = key_status(!kf_empty, kf_full,
                                        kf_ovf, 4'(kf_count));
      REG_KDATA:  readdata = {24'h0, kf_head};
      REG_DISP:   readdata = disp;
      REG_CYCLES: readdata = cycles;
      default:    readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (memwrite && region == REG_RAM) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp   <= '0;
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (memwrite && region == REG_DISP) disp <= writedata;
    end
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Data-side responder for the single-cycle RISC-V core: the memory end of the core's data interface, which carries address, write strobe, write data and read data. It serves loads combinationally in the same cycle and commits stores on the clock edge. It contains a word RAM and a small memory-mapped I/O region for the calculator. The I/O region holds a buffered keypad input queue, a display register and a free-running cycle counter. It sits between the core's data port and the board-level keypad scanner and display driver.

## Interface
Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2, at most 1024.
- FIFO_DEPTH, 4, keypad queue entries; power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-low; 0 clears all state immediately.
- addr  input  32  byte address (the core's ALU result); bits [1:0] ignored, word access only.
- memwrite  input  1  store strobe; the write commits at the next rising clk edge.
- writedata  input  32  store data.
- readdata  output  32  load data; combinational from addr and current state.
- key_valid  input  1  one-cycle push strobe from the keypad scanner.
- key_code  input  8  key code, sampled when key_valid=1.
- disp  output  32  display register contents.

## Operation
Address decode is on the full 32-bit addr:
- RAM: addr < 4*RAM_WORDS. Word index is addr[log2(RAM_WORDS)+1:2]. Read/write.
- 0x8000_0000 KEY_STATUS (RO):
  - bit0 = nonempty
  - bit1 = full
  - bits[7:4] = count
  - bit8 = overflow (sticky)
  - all other bits 0
- 0x8000_0004 KEY_DATA (RO): head entry zero-extended; 0 when the queue is empty. Reading does not pop, because the core exports no read strobe.
- 0x8000_0008 KEY_POP (WO): any store pops the head. If writedata[1]=1, the store also clears overflow. Reads return 0.
- 0x8000_000C DISP (RW): a store loads the register; disp mirrors it.
- 0x8000_0010 CYCLES (RO): 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0.
- Any other address: reads return 0, stores are ignored. Stores to RO registers are ignored.

Keypad queue behaviour:
- Circular buffer with a read pointer, a write pointer and a count; pointers wrap modulo FIFO_DEPTH.
- Push (key_valid=1):
  - not full: entry written, count +1.
  - full with no pop in the same cycle: code dropped, overflow set to 1.
- Pop (store to KEY_POP):
  - empty: ignored, with no underflow flag.
  - otherwise: count −1.
- Push and pop in the same cycle:
  - full: pop and push both happen, count unchanged, no overflow.
  - empty: push only, count becomes 1.
- Overflow set and clear in the same cycle: set wins.

## Timing
- Loads: readdata is valid combinationally in the same cycle as addr. There are no registered stages on the read path, as the single-cycle core requires.
- Stores: visible to reads in the cycle after the edge that commits them. A read of the address being written in the same cycle returns the old value.
- Keypad latency: a key_valid pulse at edge N makes KEY_STATUS and KEY_DATA reflect it from cycle N+1.
- Reset values: disp=0, CYCLES=0, count=0, pointers=0, overflow=0; readdata follows decode, so KEY_STATUS reads 0.
- RAM contents are not reset.
- Reset asserted mid-operation clears the queue and registers immediately; the CPU store pending in that cycle is lost.
- CYCLES reads 0 in the first cycle after reset deasserts, then 1, and so on.

## Structure
- Shared package data_bus_pkg holds:
  - the address constants KEY_STATUS_ADDR, KEY_DATA_ADDR, KEY_POP_ADDR, DISP_ADDR, CYCLES_ADDR and MMIO_BASE=0x8000_0000;
  - the KEY_STATUS bit positions.
- One sub-module, key_fifo. Parameter: FIFO_DEPTH. Ports: clk, reset, push, push_data[7:0], pop, clr_ovf, head[7:0], count, full, empty, overflow.
- RAM is a plain register array. Address decode, the read multiplexer, DISP and CYCLES live in the top module.

## Test plan
- Reset then idle 5 cycles:
  - disp=0, KEY_STATUS=0.
  - CYCLES reads 4 in the cycle after 4 edges.
- RAM access:
  - Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 → 0xDEADBEEF.
  - Load 0x0000_0013 → the same word.
  - Load 0x0000_0100 with RAM_WORDS=64 → 0.
- Queue order:
  - Push codes 0x11, 0x22, then read KEY_STATUS → 0x0000_0021.
  - KEY_DATA → 0x11.
  - Store to KEY_POP, then KEY_DATA → 0x22.
- Overflow:
  - Push 5 codes 0x01..0x05 into the 4-deep queue → KEY_STATUS = 0x0000_0143; head stays 0x01.
  - Store 0x2 to KEY_POP → overflow cleared, count 3, head 0x02.
- Simultaneous push and pop:
  - Full queue, key_valid with 0x99 and a KEY_POP store in the same cycle → count stays 4, overflow 0, 0x99 is the tail.
  - Empty queue, same stimulus → count 1, head 0x99.
- Reset while the queue holds 2 entries and DISP=0x1234 → all cleared asynchronously, before the next clk edge.
